// File: rtl/msrv32_trap_controller.sv
// Machine-mode trap sequencer: detects exceptions, interrupts and MRET, then
// drives the one-cycle CSR update strobes and the next-PC source select.
module msrv32_trap_controller (
  input  logic       clk_in,
  input  logic       rst_in,
  input  logic       stall_in,
  input  logic       illegal_instr_in,
  input  logic       misaligned_instr_in,
  input  logic       misaligned_load_in,
  input  logic       misaligned_store_in,
  input  logic       ecall_in,
  input  logic       ebreak_in,
  input  logic       mret_in,
  input  logic       mie_in,
  input  logic       meie_in,
  input  logic       mtie_in,
  input  logic       msie_in,
  input  logic       meip_in,
  input  logic       mtip_in,
  input  logic       msip_in,
  output logic       i_or_e_out,
  output logic [3:0] cause_out,
  output logic       set_cause_out,
  output logic       set_epc_out,
  output logic       mie_clear_out,
  output logic       mie_set_out,
  output logic       misaligned_exception_out,
  output logic       instret_inc_out,
  output logic [1:0] pc_src_out,
  output logic       flush_out,
  output logic       trap_taken_out
);

  typedef enum logic [1:0] {
    ST_RESET       = 2'd0,
    ST_OPERATING   = 2'd1,
    ST_TRAP_TAKEN  = 2'd2,
    ST_TRAP_RETURN = 2'd3
  } state_t;

  state_t     state_r;
  logic [3:0] cause_r;
  logic       i_or_e_r;
  logic       misaligned_r;

  logic       exc_s;
  logic       irq_s;
  logic [3:0] exc_cause_s;
  logic [3:0] irq_cause_s;
  logic       exc_misaligned_s;

  assign exc_s = illegal_instr_in | misaligned_instr_in | ecall_in | ebreak_in |
                 misaligned_load_in | misaligned_store_in;
  assign irq_s = mie_in & ((meie_in & meip_in) | (msie_in & msip_in) | (mtie_in & mtip_in));

  // Exception and interrupt cause selection by fixed priority
  always_comb begin
    exc_cause_s = 4'd0;
    irq_cause_s = 4'd7;
    if (illegal_instr_in) begin
      exc_cause_s = 4'd2;
    end else if (misaligned_instr_in) begin
      exc_cause_s = 4'd0;
    end else if (ecall_in) begin
      exc_cause_s = 4'd11;
    end else if (ebreak_in) begin
      exc_cause_s = 4'd3;
    end else if (misaligned_load_in) begin
      exc_cause_s = 4'd4;
    end else if (misaligned_store_in) begin
      exc_cause_s = 4'd6;
    end else begin
      exc_cause_s = 4'd0;
    end
    if (meie_in && meip_in) begin
      irq_cause_s = 4'd11;
    end else if (msie_in && msip_in) begin
      irq_cause_s = 4'd3;
    end else begin
      irq_cause_s = 4'd7;
    end
  end

  // cause 0 is only selected when misaligned_instr wins, so exc_s gates it
  assign exc_misaligned_s = exc_s & ((exc_cause_s == 4'd0) | (exc_cause_s == 4'd4) |
                                     (exc_cause_s == 4'd6));

  // Trap sequencer state, registered cause and mtval-capture flag
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_r      <= ST_RESET;
      cause_r      <= 4'd0;
      i_or_e_r     <= 1'b0;
      misaligned_r <= 1'b0;
    end else begin
      case (state_r)
        ST_RESET: state_r <= ST_OPERATING;
        ST_OPERATING: begin
          if (!stall_in) begin
            if (exc_s) begin
              state_r      <= ST_TRAP_TAKEN;
              cause_r      <= exc_cause_s;
              i_or_e_r     <= 1'b0;
              misaligned_r <= exc_misaligned_s;
            end else if (irq_s) begin
              state_r      <= ST_TRAP_TAKEN;
              cause_r      <= irq_cause_s;
              i_or_e_r     <= 1'b1;
              misaligned_r <= 1'b0;
            end else if (mret_in) begin
              state_r <= ST_TRAP_RETURN;
            end else begin
              state_r <= ST_OPERATING;
            end
          end else begin
            state_r <= ST_OPERATING;
          end
        end
        ST_TRAP_TAKEN:  state_r <= ST_OPERATING;
        ST_TRAP_RETURN: state_r <= ST_OPERATING;
        default:        state_r <= ST_RESET;
      endcase
    end
  end

  // Output decode from registered state; instret in OPERATING also sees live inputs
  always_comb begin
    pc_src_out               = 2'b00;
    flush_out                = 1'b1;
    set_cause_out            = 1'b0;
    set_epc_out              = 1'b0;
    mie_clear_out            = 1'b0;
    mie_set_out              = 1'b0;
    trap_taken_out           = 1'b0;
    misaligned_exception_out = 1'b0;
    instret_inc_out          = 1'b0;
    case (state_r)
      ST_RESET: begin
        pc_src_out = 2'b00;
        flush_out  = 1'b1;
      end
      ST_OPERATING: begin
        pc_src_out      = 2'b01;
        flush_out       = 1'b0;
        instret_inc_out = ~stall_in & ~exc_s & ~irq_s & ~mret_in;
      end
      ST_TRAP_TAKEN: begin
        pc_src_out               = 2'b11;
        set_cause_out            = 1'b1;
        set_epc_out              = 1'b1;
        mie_clear_out            = 1'b1;
        trap_taken_out           = 1'b1;
        misaligned_exception_out = misaligned_r;
      end
      ST_TRAP_RETURN: begin
        pc_src_out      = 2'b10;
        mie_set_out     = 1'b1;
        instret_inc_out = 1'b1;
      end
      default: begin
        pc_src_out = 2'b00;
        flush_out  = 1'b1;
      end
    endcase
  end

  assign cause_out  = cause_r;
  assign i_or_e_out = i_or_e_r;

  msrv32_trap_controller_checker u_checker (
    .clk_in        (clk_in),
    .rst_in        (rst_in),
    .set_cause_out (set_cause_out),
    .mie_clear_out (mie_clear_out),
    .mie_set_out   (mie_set_out)
  );

endmodule

// Strobe exclusivity properties for the trap sequencer outputs.
module msrv32_trap_controller_checker (
  input logic clk_in,
  input logic rst_in,
  input logic set_cause_out,
  input logic mie_clear_out,
  input logic mie_set_out
);

  a_mie_excl: assert property (@(posedge clk_in) disable iff (rst_in)
    !(mie_clear_out && mie_set_out));

  a_cause_vs_ret: assert property (@(posedge clk_in) disable iff (rst_in)
    !(set_cause_out && mie_set_out));

endmodule

// File: tb/tb_msrv32_trap_controller.sv
// Directed bench for msrv32_trap_controller with a cycle-level reference model.
module tb_msrv32_trap_controller;

  logic       clk_in = 1'b0;
  logic       rst_in, stall_in, illegal_instr_in, misaligned_instr_in;
  logic       misaligned_load_in, misaligned_store_in, ecall_in, ebreak_in, mret_in;
  logic       mie_in, meie_in, mtie_in, msie_in, meip_in, mtip_in, msip_in;
  logic       i_or_e_out, set_cause_out, set_epc_out, mie_clear_out, mie_set_out;
  logic       misaligned_exception_out, instret_inc_out, flush_out, trap_taken_out;
  logic [3:0] cause_out;
  logic [1:0] pc_src_out;

  int nvec  = 0;
  int nfail = 0;
  bit checking = 1'b0;

  msrv32_trap_controller dut (
    .clk_in(clk_in), .rst_in(rst_in), .stall_in(stall_in),
    .illegal_instr_in(illegal_instr_in), .misaligned_instr_in(misaligned_instr_in),
    .misaligned_load_in(misaligned_load_in), .misaligned_store_in(misaligned_store_in),
    .ecall_in(ecall_in), .ebreak_in(ebreak_in), .mret_in(mret_in), .mie_in(mie_in),
    .meie_in(meie_in), .mtie_in(mtie_in), .msie_in(msie_in),
    .meip_in(meip_in), .mtip_in(mtip_in), .msip_in(msip_in),
    .i_or_e_out(i_or_e_out), .cause_out(cause_out), .set_cause_out(set_cause_out),
    .set_epc_out(set_epc_out), .mie_clear_out(mie_clear_out), .mie_set_out(mie_set_out),
    .misaligned_exception_out(misaligned_exception_out),
    .instret_inc_out(instret_inc_out), .pc_src_out(pc_src_out),
    .flush_out(flush_out), .trap_taken_out(trap_taken_out)
  );

  always #5 clk_in = ~clk_in;

  task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
    nvec++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // 0 none, 1 exception, 2 interrupt, 3 mret
  function automatic int pred_kind();
    if (illegal_instr_in | misaligned_instr_in | ecall_in | ebreak_in |
        misaligned_load_in | misaligned_store_in) return 1;
    if (mie_in && ((meie_in && meip_in) || (msie_in && msip_in) || (mtie_in && mtip_in)))
      return 2;
    if (mret_in) return 3;
    return 0;
  endfunction

  function automatic logic [3:0] pred_cause();
    logic     flags [6];
    int       codes [6];
    flags = '{illegal_instr_in, misaligned_instr_in, ecall_in, ebreak_in,
              misaligned_load_in, misaligned_store_in};
    codes = '{2, 0, 11, 3, 4, 6};
    for (int i = 0; i < 6; i++)
      if (flags[i]) return 4'(codes[i]);
    if (meie_in && meip_in) return 4'd11;
    if (msie_in && msip_in) return 4'd3;
    return 4'd7;
  endfunction

  // Expected output record for the current cycle
  logic [1:0] m_pc;
  logic       m_flush, m_trap, m_ret, m_mis, m_ioe, m_free;
  logic [3:0] m_cause;

  always @(posedge clk_in) begin
    if (rst_in) begin
      m_pc <= 2'd0; m_flush <= 1'b1; m_trap <= 1'b0; m_ret <= 1'b0;
      m_mis <= 1'b0; m_cause <= 4'd0; m_ioe <= 1'b0; m_free <= 1'b0;
    end else if (m_free && !stall_in && (pred_kind() == 1 || pred_kind() == 2)) begin
      m_pc <= 2'd3; m_flush <= 1'b1; m_trap <= 1'b1; m_ret <= 1'b0; m_free <= 1'b0;
      m_cause <= pred_cause();
      m_ioe   <= (pred_kind() == 2);
      m_mis   <= (pred_kind() == 1) &&
                 (pred_cause() == 4'd0 || pred_cause() == 4'd4 || pred_cause() == 4'd6);
    end else if (m_free && !stall_in && pred_kind() == 3) begin
      m_pc <= 2'd2; m_flush <= 1'b1; m_trap <= 1'b0; m_ret <= 1'b1; m_free <= 1'b0;
    end else if (!m_free) begin
      m_pc <= 2'd1; m_flush <= 1'b0; m_trap <= 1'b0; m_ret <= 1'b0; m_free <= 1'b1;
    end
  end

  // Cycle-by-cycle comparison against the model
  always @(negedge clk_in) begin
    if (checking) begin
      chk("pc_src",    {2'b00, pc_src_out}, {2'b00, m_pc});
      chk("flush",     {3'b000, flush_out}, {3'b000, m_flush});
      chk("set_cause", {3'b000, set_cause_out}, {3'b000, m_trap});
      chk("set_epc",   {3'b000, set_epc_out}, {3'b000, m_trap});
      chk("mie_clear", {3'b000, mie_clear_out}, {3'b000, m_trap});
      chk("trap_tkn",  {3'b000, trap_taken_out}, {3'b000, m_trap});
      chk("mie_set",   {3'b000, mie_set_out}, {3'b000, m_ret});
      chk("misalign",  {3'b000, misaligned_exception_out}, {3'b000, m_trap & m_mis});
      chk("cause",     cause_out, m_cause);
      chk("i_or_e",    {3'b000, i_or_e_out}, {3'b000, m_ioe});
      chk("instret",   {3'b000, instret_inc_out},
          {3'b000, m_ret | (m_free & ~stall_in & (pred_kind() == 0))});
    end
  end

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic at_neg();
    @(negedge clk_in);
  endtask

  task automatic set_exc(input logic [5:0] v);
    {illegal_instr_in, misaligned_instr_in, ecall_in, ebreak_in,
     misaligned_load_in, misaligned_store_in} = v;
  endtask

  typedef struct {
    logic [5:0] flags;
    logic [3:0] cause;
    logic       mis;
  } exc_vec_t;

  exc_vec_t vecs [6];

  initial begin
    vecs = '{'{6'b101000, 4'd2, 1'b0}, '{6'b011000, 4'd0, 1'b1},
             '{6'b000110, 4'd3, 1'b0}, '{6'b000011, 4'd4, 1'b1},
             '{6'b000001, 4'd6, 1'b1}, '{6'b001100, 4'd11, 1'b0}};
    rst_in = 1'b1; stall_in = 1'b0; set_exc(6'b000000); mret_in = 1'b0;
    mie_in = 1'b0; meie_in = 1'b0; mtie_in = 1'b0; msie_in = 1'b0;
    meip_in = 1'b0; mtip_in = 1'b0; msip_in = 1'b0;

    // reset release
    tick(); checking = 1'b1;
    at_neg(); chk("lit_rst_pc", {2'b00, pc_src_out}, 4'd0); chk("lit_rst_cause", cause_out, 4'd0);
    tick(); rst_in = 1'b0;
    at_neg(); chk("lit_rel_pc", {2'b00, pc_src_out}, 4'd0); chk("lit_rel_flush", {3'b000, flush_out}, 4'd1);
    tick();
    at_neg(); chk("lit_op_pc", {2'b00, pc_src_out}, 4'd1); chk("lit_op_instret", {3'b000, instret_inc_out}, 4'd1);
    tick(); tick();

    // exception priority table
    for (int i = 0; i < 6; i++) begin
      tick(); set_exc(vecs[i].flags);
      tick();
      at_neg();
      chk("lit_exc_cause", cause_out, vecs[i].cause);
      chk("lit_exc_ioe", {3'b000, i_or_e_out}, 4'd0);
      chk("lit_exc_mis", {3'b000, misaligned_exception_out}, {3'b000, vecs[i].mis});
      chk("lit_exc_pc", {2'b00, pc_src_out}, 4'd3);
      tick(); set_exc(6'b000000);
      at_neg(); chk("lit_exc_back", {2'b00, pc_src_out}, 4'd1);
    end

    // interrupts
    tick();
    mie_in = 1'b1; {meie_in, mtie_in, msie_in, meip_in, mtip_in, msip_in} = 6'b111111;
    tick(); at_neg(); chk("lit_irq_ext", cause_out, 4'd11); chk("lit_irq_ioe", {3'b000, i_or_e_out}, 4'd1);
    tick(); meip_in = 1'b0;
    tick(); at_neg(); chk("lit_irq_sw", cause_out, 4'd3);
    tick(); mie_in = 1'b0;
    tick(); tick();
    at_neg(); chk("lit_irq_masked", {3'b000, instret_inc_out}, 4'd1);
    chk("lit_irq_masked_pc", {2'b00, pc_src_out}, 4'd1);
    {meie_in, mtie_in, msie_in, meip_in, mtip_in, msip_in} = 6'b000000;

    // stalled misaligned load
    tick(); misaligned_load_in = 1'b1; stall_in = 1'b1;
    tick(); tick(); tick();
    at_neg(); chk("lit_stall_strobe", {3'b000, set_cause_out}, 4'd0);
    chk("lit_stall_instret", {3'b000, instret_inc_out}, 4'd0);
    tick(); stall_in = 1'b0;
    tick(); at_neg(); chk("lit_load_cause", cause_out, 4'd4);
    chk("lit_load_mis", {3'b000, misaligned_exception_out}, 4'd1);
    tick(); misaligned_load_in = 1'b0;

    // mret loses to timer interrupt, then returns alone
    mret_in = 1'b1; mie_in = 1'b1; mtie_in = 1'b1; mtip_in = 1'b1;
    tick(); at_neg(); chk("lit_tmr_cause", cause_out, 4'd7); chk("lit_tmr_noset", {3'b000, mie_set_out}, 4'd0);
    tick(); mie_in = 1'b0; mtie_in = 1'b0; mtip_in = 1'b0;
    tick(); at_neg();
    chk("lit_ret_set", {3'b000, mie_set_out}, 4'd1); chk("lit_ret_pc", {2'b00, pc_src_out}, 4'd2);
    chk("lit_ret_instret", {3'b000, instret_inc_out}, 4'd1); chk("lit_ret_cause", cause_out, 4'd7);
    tick(); mret_in = 1'b0;
    at_neg(); chk("lit_ret_back", {2'b00, pc_src_out}, 4'd1);

    // reset during TRAP_TAKEN
    tick(); ecall_in = 1'b1;
    tick(); at_neg(); chk("lit_ecall_strobe", {3'b000, set_cause_out}, 4'd1); chk("lit_ecall_cause", cause_out, 4'd11);
    rst_in = 1'b1; ecall_in = 1'b0;
    tick(); at_neg();
    chk("lit_mid_rst_strobe", {3'b000, set_cause_out}, 4'd0); chk("lit_mid_rst_cause", cause_out, 4'd0);
    chk("lit_mid_rst_pc", {2'b00, pc_src_out}, 4'd0); chk("lit_mid_rst_clr", {3'b000, mie_clear_out}, 4'd0);
    rst_in = 1'b0;
    tick(); tick();
    at_neg(); chk("lit_final_pc", {2'b00, pc_src_out}, 4'd1);
    checking = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule

// File: doc/msrv32_trap_controller.md
Name: msrv32_trap_controller

Overview:
- Machine-mode trap sequencer that drives the control side of the CSR file.
- Detects synchronous exceptions, enabled pending interrupts and MRET from the decode/execute stage.
- Issues the one-cycle CSR update strobes (set_cause, set_epc, mie_clear, mie_set) and selects the next-PC source.
- Counts retired instructions via instret_inc_out and flushes the pipeline on every control transfer.

Parameters:
- NONE_RESERVED, 0, no tunable parameters; all widths are fixed by RV32I.

Ports:
- clk_in  input  1  system clock
- rst_in  input  1  reset; synchronous, active-high
- stall_in  input  1  pipeline stall (memory wait); freezes detection
- illegal_instr_in  input  1  decoder flags illegal opcode
- misaligned_instr_in  input  1  branch/jump target misaligned
- misaligned_load_in  input  1  load address misaligned
- misaligned_store_in  input  1  store address misaligned
- ecall_in  input  1  ECALL decoded
- ebreak_in  input  1  EBREAK decoded
- mret_in  input  1  MRET decoded
- mie_in  input  1  mstatus.MIE
- meie_in, mtie_in, msie_in  input  1 each  mie enable bits
- meip_in, mtip_in, msip_in  input  1 each  mip pending bits
- i_or_e_out  output  1  1 = interrupt, 0 = exception (to CSR file)
- cause_out  output  4  trap cause code (to CSR file)
- set_cause_out  output  1  strobe: load mcause/mtval
- set_epc_out  output  1  strobe: load mepc from pc
- mie_clear_out  output  1  strobe: MPIE<=MIE, MIE<=0
- mie_set_out  output  1  strobe: MIE<=MPIE, MPIE<=1
- misaligned_exception_out  output  1  mtval capture enable, valid with set_cause_out
- instret_inc_out  output  1  one instruction retired this cycle
- pc_src_out  output  2  00 boot, 01 next-pc, 10 epc, 11 trap vector
- flush_out  output  1  kill instruction in pipeline
- trap_taken_out  output  1  debug/observability: trap being entered

Behaviour:
- FSM states: RESET, OPERATING, TRAP_TAKEN, TRAP_RETURN. Encoding is free; all outputs are decoded from registered state and registered cause.
- rst_in=1 at an edge: state<=RESET, cause_out<=0, i_or_e_out<=0. This applies from any state, including mid-trap; a pending strobe is dropped.
- RESET state, outputs: pc_src_out=00, flush_out=1, all strobes 0, instret_inc_out=0.
- RESET transitions to OPERATING on the first edge with rst_in=0.
- OPERATING, outputs: pc_src_out=01, flush_out=0, strobes 0.
- OPERATING, instret_inc_out=1 only when stall_in=0 and no trap and no mret is detected that cycle (combinational from inputs).
- OPERATING detection applies only when stall_in=0. With stall_in=1 the FSM holds and all inputs are ignored.
- exc = illegal|misaligned_instr|ecall|ebreak|misaligned_load|misaligned_store.
- irq = mie_in & ((meie_in&meip_in)|(msie_in&msip_in)|(mtie_in&mtip_in)).
- Arbitration: exc > irq > mret.
- Exception priority and cause (i_or_e=0): illegal 2 > misaligned_instr 0 > ecall 11 > ebreak 3 > misaligned_load 4 > misaligned_store 6.
- Interrupt priority and cause (i_or_e=1): external 11 > software 3 > timer 7.
- On exc or irq: cause_out and i_or_e_out are registered at the same edge, and state<=TRAP_TAKEN.
- misaligned flag is registered as 1 for causes 0, 4 and 6; otherwise 0.
- On mret (no exc, no irq): state<=TRAP_RETURN. cause_out and i_or_e_out are unchanged.
- TRAP_TAKEN lasts exactly 1 cycle and ignores stall_in.
- TRAP_TAKEN outputs: set_cause_out=1, set_epc_out=1, mie_clear_out=1, trap_taken_out=1, misaligned_exception_out=registered flag, pc_src_out=11, flush_out=1, instret_inc_out=0. Next state is OPERATING.
- TRAP_RETURN lasts exactly 1 cycle.
- TRAP_RETURN outputs: mie_set_out=1, pc_src_out=10, flush_out=1, instret_inc_out=1 (mret retires). Next state is OPERATING.
- Inputs are ignored during TRAP_TAKEN, TRAP_RETURN and RESET. A new trap can be taken at the earliest in the cycle after the return to OPERATING.
- cause_out and i_or_e_out hold their values until the next trap detection.
- set_cause_out, set_epc_out, mie_clear_out and mie_set_out are never high in the same cycle as each other's opposite: mie_clear_out and mie_set_out are mutually exclusive. Assert this.
- Illegal input combinations (multiple exception flags high) are resolved purely by priority. No error output.

Test Plan:
- Reset release: rst_in 1→0 → one cycle with pc_src_out=00 and flush_out=1, then pc_src_out=01; with no events, instret_inc_out=1 every cycle.
- Illegal plus ecall in the same cycle: next cycle shows cause_out=2, i_or_e_out=0, set_cause_out=set_epc_out=mie_clear_out=1, pc_src_out=11 for exactly 1 cycle; then OPERATING.
- All interrupts enabled and pending (meip, msip, mtip with mie_in=1): cause_out=11, i_or_e_out=1. With meip cleared: cause_out=3. With mie_in=0: no trap and instret_inc_out continues.
- misaligned_load_in while stall_in=1 for 3 cycles: no trap. With stall_in=0: TRAP_TAKEN with cause_out=4 and misaligned_exception_out=1.
- mret_in plus mtip/mtie pending with mie_in=1: trap taken (cause 7), no mie_set_out. Then mret_in alone: mie_set_out=1, pc_src_out=10, flush_out=1, instret_inc_out=1 for 1 cycle.
- rst_in asserted during TRAP_TAKEN: the next cycle is RESET with all strobes 0 and cause_out=0.
